vmem_fill_ctrl: RTL and testbench



---
 rtl/vmem_fill_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_vmem_fill_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and write-port arbiter for the 240x240 3-bit video memory.
// The CPU programs a rectangle and colour through a four-register window and starts
// a fill. The engine then writes one pixel per cycle in raster order. CPU stores
// share the vmem port and always take priority, and the engine retries on the next cycle.
module vmem_fill_ctrl #(
    parameter int XMAX = 239
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [2:0]  cpu_wdata_i,
    input  logic        cfg_we_i,
    input  logic [3:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] COORD_MAX = 8'(XMAX);

    logic [1:0]  state_q, state_d;
    logic [7:0]  x0_q, y0_q, x1_q, y1_q;
    logic [2:0]  color_q;
    logic [7:0]  workX0_q, workX0_d;
    logic [7:0]  workX1_q, workX1_d;
    logic [7:0]  workY1_q, workY1_d;
    logic [2:0]  workColor_q, workColor_d;
    logic [7:0]  curX_q, curX_d;
    logic [7:0]  curY_q, curY_d;
    logic        err_q, err_d;
    logic        aborted_q, aborted_d;
    logic [31:0] rdata_q, rdata_d;
    logic        vmemWe_q;
    logic [15:0] vmemAddr_q;
    logic [2:0]  vmemWdata_q;

    logic ctrlWrite;
    logic startReq;
    logic abortReq;
    logic rectBad;
    logic engineWrite;
    logic lastPixel;
    logic unusedCfgBits;

    assign ctrlWrite     = cfg_we_i && (cfg_addr_i == 4'h0);
    assign startReq      = ctrlWrite && cfg_wdata_i[0];
    assign abortReq      = ctrlWrite && cfg_wdata_i[1];
    assign rectBad       = (x0_q > x1_q) || (y0_q > y1_q) ||
                           (x1_q > COORD_MAX) || (y1_q > COORD_MAX);
    // An ABORT arriving during RUN also suppresses that cycle's pixel, so nothing
    // more is written once the abort has been seen.
    assign engineWrite   = (state_q == ST_RUN) && !cpu_we_i && !abortReq;
    assign lastPixel     = (curX_q == workX1_q) && (curY_q == workY1_q);
    assign unusedCfgBits = ^cfg_wdata_i[31:16];

    // Shadow registers P0/P1/COLOR: CPU-writable at any time, never read by a running fill
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q    <= 8'd0;
            y0_q    <= 8'd0;
            x1_q    <= 8'd0;
            y1_q    <= 8'd0;
            color_q <= 3'd0;
        end else if (cfg_we_i) begin
            case (cfg_addr_i)
                4'h4: begin
                    x0_q <= cfg_wdata_i[7:0];
                    y0_q <= cfg_wdata_i[15:8];
                end
                4'h8: begin
                    x1_q <= cfg_wdata_i[7:0];
                    y1_q <= cfg_wdata_i[15:8];
                end
                4'hC: color_q <= cfg_wdata_i[2:0];
                default: ;
            endcase
        end
    end

    // Fill FSM next state: start/validation, raster stepping, abort, completion
    always_comb begin
        state_d     = state_q;
        workX0_d    = workX0_q;
        workX1_d    = workX1_q;
        workY1_d    = workY1_q;
        workColor_d = workColor_q;
        curX_d      = curX_q;
        curY_d      = curY_q;
        err_d       = err_q;
        aborted_d   = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (abortReq) begin
                    aborted_d = 1'b1;
                end else if (startReq) begin
                    aborted_d = 1'b0;
                    if (rectBad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d       = 1'b0;
                        workX0_d    = x0_q;
                        workX1_d    = x1_q;
                        workY1_d    = y1_q;
                        workColor_d = color_q;
                        curX_d      = x0_q;
                        curY_d      = y0_q;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abortReq) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (engineWrite) begin
                    if (lastPixel) begin
                        state_d = ST_DONE;
                    end else if (curX_q == workX1_q) begin
                        curX_d = workX0_q;
                        curY_d = curY_q + 8'd1;
                    end else begin
                        curX_d = curX_q + 8'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and working-register state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            workX0_q    <= 8'd0;
            workX1_q    <= 8'd0;
            workY1_q    <= 8'd0;
            workColor_q <= 3'd0;
            curX_q      <= 8'd0;
            curY_q      <= 8'd0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            workX0_q    <= workX0_d;
            workX1_q    <= workX1_d;
            workY1_q    <= workY1_d;
            workColor_q <= workColor_d;
            curX_q      <= curX_d;
            curY_q      <= curY_d;
            err_q       <= err_d;
            aborted_q   <= aborted_d;
        end
    end

    // Register read mux; unmapped offsets and unused bits read as zero
    always_comb begin
        rdata_d = 32'd0;
        case (cfg_addr_i)
            4'h0: rdata_d = {29'd0, err_q, aborted_q, (state_q == ST_RUN)};
            4'h4: rdata_d = {16'd0, y0_q, x0_q};
            4'h8: rdata_d = {16'd0, y1_q, x1_q};
            4'hC: rdata_d = {29'd0, color_q};
            default: rdata_d = 32'd0;
        endcase
    end

    // Registered read data, one cycle behind cfg_addr_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Registered vmem port mux: CPU store wins, otherwise the engine pixel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vmemWe_q    <= 1'b0;
            vmemAddr_q  <= 16'd0;
            vmemWdata_q <= 3'd0;
        end else if (cpu_we_i) begin
            vmemWe_q    <= 1'b1;
            vmemAddr_q  <= cpu_addr_i;
            vmemWdata_q <= cpu_wdata_i;
        end else if (engineWrite) begin
            vmemWe_q    <= 1'b1;
            vmemAddr_q  <= {curY_q, curX_q};
            vmemWdata_q <= workColor_q;
        end else begin
            vmemWe_q    <= 1'b0;
        end
    end

    assign cfg_rdata_o  = rdata_q;
    assign vmem_we_o    = vmemWe_q;
    assign vmem_addr_o  = vmemAddr_q;
    assign vmem_wdata_o = vmemWdata_q;
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Testbench for vmem_fill_ctrl: scoreboard of expected vmem writes built from a
// raster-order pixel list plus CPU-priority arbitration, checked by a separate monitor.
module tb_vmem_fill_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_we_i = 1'b0;
    logic [15:0] cpu_addr_i = 16'd0;
    logic [2:0]  cpu_wdata_i = 3'd0;
    logic        cfg_we_i = 1'b0;
    logic [3:0]  cfg_addr_i = 4'd0;
    logic [31:0] cfg_wdata_i = 32'd0;
    logic [31:0] cfg_rdata_o;
    logic        vmem_we_o;
    logic [15:0] vmem_addr_o;
    logic [2:0]  vmem_wdata_o;
    logic        busy_o;
    logic        done_o;

    int  total = 0;
    int  bad = 0;
    int  doneCount = 0;
    int  busyCount = 0;
    bit  sawF0 = 1'b0;
    wr_t expQ[$];

    vmem_fill_ctrl #(.XMAX(239)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .vmem_we_o    (vmem_we_o),
        .vmem_addr_o  (vmem_addr_o),
        .vmem_wdata_o (vmem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Free-running 10 ns clock
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every vmem write and tallies busy/done cycles
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (done_o) doneCount++;
            if (busy_o) busyCount++;
            if (vmem_we_o) begin
                if (vmem_addr_o == 16'h00F0) sawF0 = 1'b1;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected write: got addr 0x%0h data %0d, expected none",
                             vmem_addr_o, vmem_wdata_o);
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("vmem addr", {16'd0, vmem_addr_o}, {16'd0, e.addr});
                    checkOutput("vmem data", {29'd0, vmem_wdata_o}, {29'd0, e.data});
                end
            end
        end
    end

    task automatic cfgWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        @(negedge clk_i);
        cfg_we_i    = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_i);
        cfg_we_i   = 1'b0;
        cfg_addr_i = a;
        @(negedge clk_i);
        d = cfg_rdata_o;
    endtask

    // mode 0: run to completion, 1: ABORT after modeAt engine pixels, 2: async reset after modeAt RUN cycles
    task automatic applyStimulus(input int x0, input int y0, input int x1, input int y1,
                                 input int col, input int cpuPct, input int forceCpu,
                                 input int mode, input int modeAt);
        wr_t         pix[$];
        wr_t         w;
        int          doneBefore;
        int          busyBefore;
        int          runCycles;
        int          engineIssued;
        bit          valid;
        logic [31:0] st;
        cfgWrite(4'h4, {16'd0, 8'(y0), 8'(x0)});
        cfgWrite(4'h8, {16'd0, 8'(y1), 8'(x1)});
        cfgWrite(4'hC, 32'(col));
        valid = (x0 <= x1) && (y0 <= y1) && (x1 <= 239) && (y1 <= 239);
        if (valid) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    w.addr = {8'(y), 8'(x)};
                    w.data = 3'(col);
                    pix.push_back(w);
                end
            end
        end
        doneBefore   = doneCount;
        busyBefore   = busyCount;
        runCycles    = 0;
        engineIssued = 0;
        cfgWrite(4'h0, 32'h1);
        while (pix.size() > 0) begin
            if (mode == 1 && engineIssued == modeAt) begin
                cpu_we_i    = 1'b0;
                cfg_we_i    = 1'b1;
                cfg_addr_i  = 4'h0;
                cfg_wdata_i = 32'h2;
                @(negedge clk_i);
                cfg_we_i    = 1'b0;
                break;
            end
            if (mode == 2 && runCycles == modeAt) begin
                cpu_we_i = 1'b0;
                @(posedge clk_i);
                #3 rst_i = 1'b1;
                #1;
                checkOutput("reset vmem outs", {12'd0, vmem_we_o, vmem_addr_o, vmem_wdata_o}, 32'd0);
                checkOutput("reset flags", {30'd0, busy_o, done_o}, 32'd0);
                checkOutput("reset rdata", cfg_rdata_o, 32'd0);
                expQ.delete();
                @(negedge clk_i);
                rst_i = 1'b0;
                break;
            end
            if (runCycles == forceCpu || $urandom_range(99) < cpuPct) begin
                cpu_we_i    = 1'b1;
                cpu_addr_i  = (runCycles == forceCpu) ? 16'h0000 : 16'($urandom());
                cpu_wdata_i = (runCycles == forceCpu) ? 3'd7 : 3'($urandom());
                w.addr = cpu_addr_i;
                w.data = cpu_wdata_i;
                expQ.push_back(w);
            end else begin
                cpu_we_i = 1'b0;
                expQ.push_back(pix.pop_front());
                engineIssued++;
            end
            runCycles++;
            @(negedge clk_i);
        end
        cpu_we_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("pending writes", 32'(expQ.size()), 32'd0);
        checkOutput("busy now", {31'd0, busy_o}, 32'd0);
        readReg(4'h0, st);
        if (mode == 0) begin
            checkOutput("done pulses", 32'(doneCount - doneBefore), 32'd1);
            checkOutput("busy cycles", 32'(busyCount - busyBefore), 32'(runCycles));
            checkOutput("status", st, valid ? 32'h0 : 32'h4);
        end else if (mode == 1) begin
            checkOutput("abort no done", 32'(doneCount - doneBefore), 32'd0);
            checkOutput("abort status", st, 32'h2);
        end else begin
            repeat (8) @(negedge clk_i);
            checkOutput("post-reset writes", 32'(expQ.size()), 32'd0);
            checkOutput("post-reset done", 32'(doneCount - doneBefore), 32'd0);
            checkOutput("post-reset status", st, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          doneBefore;
        #3;
        checkOutput("init vmem outs", {12'd0, vmem_we_o, vmem_addr_o, vmem_wdata_o}, 32'd0);
        checkOutput("init flags", {30'd0, busy_o, done_o}, 32'd0);
        checkOutput("init rdata", cfg_rdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        readReg(4'h0, rd);
        checkOutput("reset status", rd, 32'h0);

        cfgWrite(4'h4, 32'hFFFF_1234);
        readReg(4'h4, rd);
        checkOutput("P0 readback", rd, 32'h0000_1234);
        cfgWrite(4'hC, 32'hFFFF_FFFF);
        readReg(4'hC, rd);
        checkOutput("COLOR readback", rd, 32'h7);
        readReg(4'h2, rd);
        checkOutput("unmapped read", rd, 32'h0);

        $display("[TB] basic fill");
        applyStimulus(10, 20, 12, 21, 5, 0, -1, 0, 0);
        $display("[TB] fill with CPU store in third slot");
        applyStimulus(10, 20, 12, 21, 5, 0, 2, 0, 0);
        $display("[TB] invalid rectangles");
        applyStimulus(50, 20, 40, 21, 3, 0, -1, 0, 0);
        applyStimulus(0, 30, 5, 20, 3, 0, -1, 0, 0);
        applyStimulus(230, 0, 240, 1, 3, 0, -1, 0, 0);
        $display("[TB] single pixel");
        applyStimulus(239, 239, 239, 239, 6, 0, -1, 0, 0);

        $display("[TB] random fills with CPU traffic");
        for (int i = 0; i < 8; i++) begin
            int rx, ry;
            rx = $urandom_range(232);
            ry = $urandom_range(232);
            applyStimulus(rx, ry, rx + $urandom_range(6), ry + $urandom_range(6),
                          $urandom_range(7), 30, -1, 0, 0);
        end

        $display("[TB] abort and restart");
        applyStimulus(30, 40, 49, 59, 2, 0, -1, 1, 100);
        applyStimulus(30, 40, 49, 59, 2, 0, -1, 0, 0);

        $display("[TB] START with ABORT");
        doneBefore = doneCount;
        cfgWrite(4'h0, 32'h3);
        repeat (3) @(negedge clk_i);
        readReg(4'h0, rd);
        checkOutput("start+abort status", rd, 32'h2);
        checkOutput("start+abort no done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("start+abort writes", 32'(expQ.size()), 32'd0);

        $display("[TB] async reset mid-run");
        applyStimulus(100, 100, 119, 119, 4, 20, -1, 2, 50);

        $display("[TB] full screen");
        sawF0 = 1'b0;
        applyStimulus(0, 0, 239, 239, 1, 0, -1, 0, 0);
        checkOutput("0x00F0 untouched", {31'd0, sawF0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
